// File: rtl/g2_run_ctrl.sv
// g2_run_ctrl: run sequencer around a g2 correlation calculator.
// One run goes IDLE -> ACQ -> DRAIN -> TRIG -> READ -> DONE -> IDLE.
// It gates the a1/a2 sample streams while acquiring, lets the calculator
// pipeline drain, pulses the readout trigger, and tracks the histogram
// readout word by word. Abort only shortens acquisition: once the gate
// closes, the run always finishes its readout so the histogram is cleared.
//
// Handshake semantics (every valid/ready pair here): a transfer happens on a
// rising clk edge where valid and ready are both high. The sender keeps valid
// and its data stable until that edge. The receiver may change ready at any
// time. During READ the block only observes g2V/g2R and never drives them.
module g2_run_ctrl #(
    parameter int CNT_BIT   = 31,
    parameter int BIN_BIT   = 9,
    parameter int DRAIN_CYC = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_BIT:0] acqLen,
    input  logic             a1VIn,
    output logic             a1RIn,
    input  logic             a2VIn,
    output logic             a2RIn,
    output logic             a1V,
    input  logic             a1R,
    output logic             a2V,
    input  logic             a2R,
    output logic             calRst,
    input  logic             g2V,
    input  logic             g2R,
    output logic             g2Last,
    output logic             busy,
    output logic             done,
    output logic [CNT_BIT:0] a1Cnt,
    output logic [15:0]      frameCnt,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACQ   = 3'd1,
        DRAIN = 3'd2,
        TRIG  = 3'd3,
        READ  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // The drain counter only needs to count to DRAIN_CYC-1.
    localparam int              DW         = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [BIN_BIT:0] WORD_LAST = '1;   // NBINS-1

    state_t             state;
    logic               gate;
    logic [CNT_BIT:0]   len_q;
    logic [BIN_BIT:0]   word_cnt;
    logic [DW-1:0]      drain_cnt;

    logic               a1_accept;
    logic               g2_hs;

    assign a1_accept = a1VIn & a1R;
    assign g2_hs     = g2V & g2R;

    // Stream gating: everything is closed unless the registered gate is high.
    assign a1V   = a1VIn & gate;
    assign a1RIn = a1R & gate;
    assign a2V   = a2VIn & gate;
    assign a2RIn = a2R & gate;

    // Flags the histogram word currently presented as the last one.
    assign g2Last = (state == READ) & g2V & (word_cnt == WORD_LAST);

    assign dbg_state = state;

    // Run sequencer: state, counters and registered outputs.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            gate      <= 1'b0;
            calRst    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            len_q     <= '0;
            a1Cnt     <= '0;
            word_cnt  <= '0;
            drain_cnt <= '0;
            frameCnt  <= '0;
        end else begin
            calRst <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is meaningless here; start alone decides.
                    if (start) begin
                        len_q     <= acqLen;
                        a1Cnt     <= '0;
                        word_cnt  <= '0;
                        drain_cnt <= '0;
                        busy      <= 1'b1;
                        if (acqLen == '0) begin
                            state <= DRAIN;
                            gate  <= 1'b0;
                        end else begin
                            state <= ACQ;
                            gate  <= 1'b1;
                        end
                    end
                end
                ACQ: begin
                    if (a1_accept) begin
                        a1Cnt <= a1Cnt + (CNT_BIT+1)'(1);
                    end
                    // Closing the gate on the last accept lets exactly
                    // len_q samples through; abort closes it right away.
                    if ((a1_accept && (a1Cnt == len_q - (CNT_BIT+1)'(1))) || abort) begin
                        state     <= DRAIN;
                        gate      <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state  <= TRIG;
                        calRst <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                TRIG: begin
                    // calRst falls on this edge, which starts the readout.
                    state <= READ;
                end
                READ: begin
                    if (g2_hs) begin
                        word_cnt <= word_cnt + (BIN_BIT+1)'(1);
                        if (word_cnt == WORD_LAST) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            frameCnt <= frameCnt + 16'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gate  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_g2_run_ctrl.sv
// tb_g2_run_ctrl: directed bench for g2_run_ctrl with default parameters
// (1024-word histogram, 16-cycle drain). Inputs are driven and outputs
// sampled on the falling clk edge.
module tb_g2_run_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic        abort;
    logic [31:0] acqLen;
    logic        a1VIn;
    logic        a1RIn;
    logic        a2VIn;
    logic        a2RIn;
    logic        a1V;
    logic        a1R;
    logic        a2V;
    logic        a2R;
    logic        calRst;
    logic        g2V;
    logic        g2R;
    logic        g2Last;
    logic        busy;
    logic        done;
    logic [31:0] a1Cnt;
    logic [15:0] frameCnt;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    // Expected frame count for each completed run, queued in run order.
    logic [31:0] exp_q[$];

    // Clock / reset block
    always #5 clk = ~clk;

    g2_run_ctrl dut (
        .clk      (clk),
        .RST      (RST),
        .start    (start),
        .abort    (abort),
        .acqLen   (acqLen),
        .a1VIn    (a1VIn),
        .a1RIn    (a1RIn),
        .a2VIn    (a2VIn),
        .a2RIn    (a2RIn),
        .a1V      (a1V),
        .a1R      (a1R),
        .a2V      (a2V),
        .a2R      (a2R),
        .calRst   (calRst),
        .g2V      (g2V),
        .g2R      (g2R),
        .g2Last   (g2Last),
        .busy     (busy),
        .done     (done),
        .a1Cnt    (a1Cnt),
        .frameCnt (frameCnt),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Driver: one-cycle start request (optionally with abort alongside).
    task automatic start_run(input logic [31:0] len, input logic with_abort);
        acqLen = len;
        start  = 1'b1;
        abort  = with_abort;
        tick();
        start  = 1'b0;
        abort  = 1'b0;
    endtask

    // Counts a1 transfers through the gate until ACQ is left.
    task automatic acq_count(output int acc);
        int n;
        acc = 0;
        n   = 0;
        while (dbg_state == 3'd1 && n < 500) begin
            if (a1V && a1R) acc++;
            tick();
            n++;
        end
    endtask

    // Measures DRAIN length, gate leakage, and the one-cycle trigger.
    task automatic drain_trig(input string tag);
        int d;
        int leak;
        d    = 0;
        leak = 0;
        while (dbg_state == 3'd2 && d < 200) begin
            if (a1V || a1RIn || a2V || a2RIn) leak++;
            d++;
            tick();
        end
        check({tag, "_drain_len"}, d, 16);
        check({tag, "_gate_closed"}, leak, 0);
        check({tag, "_calrst_high"}, calRst, 1);
        check({tag, "_trig_state"}, dbg_state, 3);
        tick();
        check({tag, "_calrst_low"}, calRst, 0);
        check({tag, "_read_state"}, dbg_state, 4);
    endtask

    // Histogram readout. mode 0: always ready, 1: g2R toggles, 2: random.
    // At word inject_word start and abort are raised for one cycle.
    task automatic readout(input string tag, input int mode, input int inject_word);
        int w;
        int n;
        int mism;
        int seen;
        logic injected;
        logic exp_last;
        logic hs;
        logic [31:0] exp_frame;
        w = 0; n = 0; mism = 0; seen = 0; injected = 1'b0;
        exp_frame = exp_q.pop_front();
        while (dbg_state == 3'd4 && n < 20000) begin
            case (mode)
                0: begin g2V = 1'b1; g2R = 1'b1; end
                1: begin g2V = 1'b1; g2R = n[0]; end
                default: begin
                    g2V = 1'($urandom_range(0, 1));
                    g2R = 1'($urandom_range(0, 1));
                end
            endcase
            if (w == inject_word && !injected) begin
                start = 1'b1; abort = 1'b1; injected = 1'b1;
            end else begin
                start = 1'b0; abort = 1'b0;
            end
            #1;
            exp_last = g2V && (w == 1023);
            if (g2Last !== exp_last) mism++;
            if (g2Last) seen++;
            hs = g2V && g2R;
            tick();
            n++;
            if (hs) w++;
        end
        start = 1'b0; abort = 1'b0; g2V = 1'b0; g2R = 1'b0;
        check({tag, "_words"}, w, 1024);
        check({tag, "_g2last_wrong"}, mism, 0);
        check({tag, "_g2last_seen"}, 32'(seen > 0), 1);
        check({tag, "_done_state"}, dbg_state, 5);
        check({tag, "_done_pulse"}, done, 1);
        check({tag, "_frame_cnt"}, frameCnt, exp_frame);
        tick();
        check({tag, "_done_clear"}, done, 0);
        check({tag, "_idle"}, dbg_state, 0);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        int acc;
        RST = 1'b1; start = 1'b0; abort = 1'b0; acqLen = '0;
        a1VIn = 1'b1; a2VIn = 1'b1; a1R = 1'b1; a2R = 1'b1;
        g2V = 1'b1; g2R = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_state", dbg_state, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_calrst", calRst, 0);
        check("rst_a1cnt", a1Cnt, 0);
        check("rst_frame", frameCnt, 0);
        check("rst_a1v", a1V, 0);
        check("rst_a2rin", a2RIn, 0);
        check("rst_g2last", g2Last, 0);
        g2V = 1'b0; g2R = 1'b0;
        RST = 1'b0;
        tick();
        check("idle_after_rst", dbg_state, 0);

        // Normal run, acqLen=5
        start_run(5, 1'b0);
        check("n_acq_state", dbg_state, 1);
        check("n_busy", busy, 1);
        check("n_a1v", a1V, 1);
        check("n_a1rin", a1RIn, 1);
        check("n_a2v", a2V, 1);
        check("n_a2rin", a2RIn, 1);
        acq_count(acc);
        check("n_accepts", acc, 5);
        check("n_a1cnt", a1Cnt, 5);
        exp_q.push_back(1);
        drain_trig("n");
        readout("n", 0, -1);
        check("n_a1cnt_hold", a1Cnt, 5);

        // Abort after 3 accepts, acqLen=100 (back-to-back with previous done)
        start_run(100, 1'b0);
        tick();
        tick();
        check("ab_a1cnt_2", a1Cnt, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_a1cnt_3", a1Cnt, 3);
        check("ab_drain_state", dbg_state, 2);
        check("ab_a1v_closed", a1V, 0);
        exp_q.push_back(2);
        drain_trig("ab");
        readout("ab", 0, -1);

        // Start and abort during READ at word 500 are ignored
        start_run(7, 1'b0);
        acq_count(acc);
        check("rd_accepts", acc, 7);
        exp_q.push_back(3);
        drain_trig("rd");
        readout("rd", 0, 500);
        check("rd_a1cnt_hold", a1Cnt, 7);
        tick();
        check("rd_stay_idle", dbg_state, 0);
        check("rd_frame_once", frameCnt, 3);

        // acqLen=0 goes straight to DRAIN
        check("z_idle_a1v", a1V, 0);
        start_run(0, 1'b0);
        check("z_drain_state", dbg_state, 2);
        check("z_a1cnt", a1Cnt, 0);
        exp_q.push_back(4);
        drain_trig("z");
        readout("z", 0, -1);

        // Start+abort in IDLE starts a run; readout under toggling g2R
        start_run(4, 1'b1);
        check("sa_acq_state", dbg_state, 1);
        acq_count(acc);
        check("sa_accepts", acc, 4);
        exp_q.push_back(5);
        drain_trig("sa");
        readout("bp", 1, -1);

        // Random g2V/g2R readout
        start_run(3, 1'b0);
        acq_count(acc);
        check("rn_accepts", acc, 3);
        exp_q.push_back(6);
        drain_trig("rn");
        readout("rn", 2, -1);

        // Asynchronous reset during DRAIN
        start_run(2, 1'b0);
        tick();
        tick();
        check("rs_drain_state", dbg_state, 2);
        check("rs_a1cnt_pre", a1Cnt, 2);
        #2;
        RST = 1'b1;
        #1;
        check("rs_state", dbg_state, 0);
        check("rs_busy", busy, 0);
        check("rs_a1cnt", a1Cnt, 0);
        check("rs_frame", frameCnt, 0);
        check("rs_calrst", calRst, 0);
        check("rs_done", done, 0);
        #1;
        RST = 1'b0;
        @(negedge clk);
        check("rs_idle_after", dbg_state, 0);
        check("rs_no_calrst", calRst, 0);
        start_run(5, 1'b0);
        acq_count(acc);
        check("rs_accepts", acc, 5);
        exp_q.push_back(1);
        drain_trig("rs");
        readout("rs", 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/g2_run_ctrl.md
G2_RUN_CTRL -- requirements
Module: g2_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_BIT, default 31: MSB index of the acquisition length and sample counter.
REQ-002 SHALL have parameter BIN_BIT, default 9: MSB index of the g2 bin address; NBINS = 2^(BIN_BIT+1).
REQ-003 SHALL have parameter DRAIN_CYC, default 16: number of idle cycles after gating closes and before the readout trigger.
REQ-004 SHALL have ports:
 - clk  in  1  sole clock; all logic rising-edge.
 - RST  in  1  asynchronous, active-high reset.
 - start  in  1  single-cycle run request.
 - abort  in  1  ends acquisition early.
 - acqLen  in  CNT_BIT+1  number of a1 samples per run; sampled on accepted start.
 - a1VIn  in  1  upstream a1 valid.
 - a1RIn  out  1  upstream a1 ready.
 - a2VIn  in  1  upstream a2 valid.
 - a2RIn  out  1  upstream a2 ready.
 - a1V  out  1  calculator a1 valid.
 - a1R  in  1  calculator a1 ready.
 - a2V  out  1  calculator a2 valid.
 - a2R  in  1  calculator a2 ready.
 - calRst  out  1  calculator readout trigger; readout starts on its falling edge.
 - g2V  in  1  calculator histogram word valid (monitored).
 - g2R  in  1  downstream histogram ready (monitored).
 - g2Last  out  1  marks the final histogram word.
 - busy  out  1  high in any state except IDLE.
 - done  out  1  one-cycle end-of-run pulse.
 - a1Cnt  out  CNT_BIT+1  a1 samples accepted in the current run.
 - frameCnt  out  16  number of completed runs.

Function
REQ-005 SHALL implement states IDLE, ACQ, DRAIN, TRIG, READ, DONE, registered on clk.
REQ-006 SHALL drive gate = (state==ACQ), registered.
 - a1V = a1VIn & gate; a1RIn = a1R & gate.
 - a2V = a2VIn & gate; a2RIn = a2R & gate.
 - All four are combinational from gate.
REQ-007 IDLE: start=1 SHALL latch acqLen, clear a1Cnt and the word counter, and go to ACQ next cycle; if acqLen==0, it SHALL go to DRAIN instead.
REQ-008 ACQ: a1Cnt SHALL increment on each cycle where a1VIn & a1R is high.
REQ-009 ACQ: when an accept occurs with a1Cnt == latched acqLen-1, the state SHALL go to DRAIN next cycle; gate is low from that cycle on, so exactly acqLen a1 samples pass.
REQ-010 ACQ: abort=1 SHALL go to DRAIN next cycle; an a1 accept in the same cycle still counts.
REQ-011 DRAIN: gates SHALL stay closed for exactly DRAIN_CYC cycles, then go to TRIG.
REQ-012 TRIG: calRst SHALL be 1 for exactly one cycle, then go to READ; calRst SHALL be 0 in all other states.
REQ-013 READ: the word counter (BIN_BIT+1 bits) SHALL increment on each g2V & g2R.
REQ-014 READ: g2Last = READ & g2V & (wordCnt == NBINS-1), combinational.
REQ-015 READ: when g2V & g2R occurs with wordCnt == NBINS-1, the state SHALL go to DONE.
REQ-016 DONE: done=1 for one cycle, frameCnt SHALL increment (wrapping 0xFFFF->0), and the state SHALL return to IDLE.
REQ-017 start outside IDLE SHALL be ignored; abort outside ACQ SHALL be ignored, so a started readout always completes and the calculator histogram is cleared.
REQ-018 start and abort together in IDLE SHALL start a run; the abort is ignored.
REQ-019 a1Cnt SHALL hold its final value from DRAIN through IDLE until the next accepted start.
REQ-020 Turnaround from done to the next ACQ SHALL be 2 cycles minimum: DONE->IDLE, then start accepted in IDLE.

Reset
REQ-021 RST=1 SHALL asynchronously force:
 - state = IDLE;
 - a1Cnt, wordCnt, the drain counter and frameCnt = 0;
 - gate, calRst, done = 0.
REQ-022 RST asserted mid-run (any state) SHALL abandon the run with no done pulse and no calRst edge; the histogram content is then undefined until the next complete run.
REQ-023 After RST deasserts, the first rising clk edge SHALL evaluate IDLE normally.

Verification
REQ-024 Normal run: acqLen=5, a1VIn=a1R=1 continuously.
 - Exactly 5 a1 accepts, a1Cnt=5.
 - DRAIN lasts 16 cycles, then calRst is high for 1 cycle.
 - After 1024 g2V&g2R handshakes, g2Last is on word 1023, done pulses, frameCnt=1.
REQ-025 Abort in ACQ after 3 accepts (acqLen=100): a1Cnt=3, gate low next cycle, full 1024-word readout follows, done=1.
REQ-026 Abort or start during READ (word 500): both ignored; readout completes at word 1023; frameCnt increments once.
REQ-027 acqLen=0: no a1V asserted, IDLE->DRAIN directly, readout still completes with 1024 words.
REQ-028 Backpressure: g2R toggled 1/0 during READ -> wordCnt advances only on handshake cycles; g2Last is asserted only with word 1023 presented.
REQ-029 RST pulse during DRAIN: all outputs 0 immediately without waiting for clk; a new start afterwards runs normally with frameCnt counting from 0.
